// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle MIPS control unit. Steps one instruction at a time through
// FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It produces registered
// per-state datapath strobes. It also handles a data-memory ready handshake
// with a timeout, flags illegal opcodes and counts retired instructions.
//
// Ports
//   c_clk          clock, all state updates on the rising edge
//   c_rst          asynchronous active-high reset
//   c_i_ce         run enable; sampled in IDLE and at each instruction end
//   c_i_opcode     opcode of the fetched instruction, valid in DECODE
//   c_i_funct      funct field, valid in DECODE
//   c_i_zero       ALU zero flag, valid in EXECUTE
//   c_i_mem_ready  data memory completion, sampled in MEMORY
//   c_o_fetch_ce   fetch enable / PC advance (FETCH)
//   c_o_RegDst .. c_o_MemtoReg   registered datapath controls
//   c_o_change_pc  taken branch, combinational Branch & c_i_zero
//   c_o_state      current state encoding
//   c_o_illegal    one-cycle pulse after DECODE of an unknown opcode
//   c_o_mem_err    sticky memory-timeout flag
//   c_o_retired    completed-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6,
    parameter int MEM_WAIT_MAX = 15,
    parameter int RET_WIDTH    = 16
) (
    input  logic                    c_clk,
    input  logic                    c_rst,
    input  logic                    c_i_ce,
    input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  c_i_funct,
    input  logic                    c_i_zero,
    input  logic                    c_i_mem_ready,
    output logic                    c_o_fetch_ce,
    output logic                    c_o_RegDst,
    output logic                    c_o_RegWrite,
    output logic                    c_o_ALUSrc,
    output logic                    c_o_Branch,
    output logic                    c_o_MemRead,
    output logic                    c_o_MemWrite,
    output logic                    c_o_MemtoReg,
    output logic                    c_o_change_pc,
    output logic [2:0]              c_o_state,
    output logic                    c_o_illegal,
    output logic                    c_o_mem_err,
    output logic [RET_WIDTH-1:0]    c_o_retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;

    localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'h23);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'h2B);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_SLTI = OPCODE_WIDTH'(6'h0A);
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(6'h0C);
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = OPCODE_WIDTH'(6'h0D);

    // The wait counter times out on the cycle it would reach MEM_WAIT_MAX,
    // so MEMORY lasts at most MEM_WAIT_MAX cycles.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    logic [2:0]              state_q, state_d, end_state;
    logic [OPCODE_WIDTH-1:0] opcode_q, op_sel;
    logic [FUNCT_WIDTH-1:0]  funct_q;
    logic [7:0]              wait_q;
    logic                    is_r, is_lw, is_sw, is_beq, is_ialu, is_legal;
    logic                    retire, timeout, illegal_d;

    // funct is latched with the opcode for the datapath's ALU decoder; this
    // unit's sequencing never depends on it.
    logic unused_funct;
    assign unused_funct = ^funct_q;

    // In DECODE the opcode is latched on the same edge that leaves it, so the
    // decisions made on that edge use the live input.
    always_comb begin
        op_sel   = (state_q == S_DECODE) ? c_i_opcode : opcode_q;
        is_r     = (op_sel == OP_R);
        is_lw    = (op_sel == OP_LW);
        is_sw    = (op_sel == OP_SW);
        is_beq   = (op_sel == OP_BEQ);
        is_ialu  = (op_sel == OP_ADDI) || (op_sel == OP_SLTI) ||
                   (op_sel == OP_ANDI) || (op_sel == OP_ORI);
        is_legal = is_r || is_lw || is_sw || is_beq || is_ialu;
    end

    assign end_state = c_i_ce ? S_FETCH : S_IDLE;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        retire    = 1'b0;
        timeout   = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:   if (c_i_ce) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d   = end_state;
                    illegal_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (is_beq) begin
                    state_d = end_state;
                    retire  = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // ready has priority over a timeout landing in the same cycle
                if (c_i_mem_ready) begin
                    if (is_lw) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = end_state;
                        retire  = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = end_state;
                    timeout = 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = end_state;
                retire  = 1'b1;
            end
            default: state_d = S_IDLE;   // unused encodings 6 and 7
        endcase
    end

    // Controls are registered from the state being entered, so each strobe is
    // valid for exactly the cycles spent in its state.
    always_ff @(posedge c_clk or posedge c_rst) begin
        if (c_rst) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            funct_q      <= '0;
            wait_q       <= '0;
            c_o_fetch_ce <= 1'b0;
            c_o_RegDst   <= 1'b0;
            c_o_RegWrite <= 1'b0;
            c_o_ALUSrc   <= 1'b0;
            c_o_Branch   <= 1'b0;
            c_o_MemRead  <= 1'b0;
            c_o_MemWrite <= 1'b0;
            c_o_MemtoReg <= 1'b0;
            c_o_illegal  <= 1'b0;
            c_o_mem_err  <= 1'b0;
            c_o_retired  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, regardless of statement order.
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= c_i_opcode;
                funct_q  <= c_i_funct;
            end
            // Held at zero outside MEMORY, so it starts from zero on entry.
            if (state_q != S_MEMORY)  wait_q <= '0;
            else if (!c_i_mem_ready)  wait_q <= wait_q + 8'd1;

            c_o_fetch_ce <= (state_d == S_FETCH);
            c_o_ALUSrc   <= ((state_d == S_EXECUTE) && (is_lw || is_sw || is_ialu)) ||
                            (state_d == S_MEMORY);
            c_o_Branch   <= (state_d == S_EXECUTE) && is_beq;
            c_o_MemRead  <= (state_d == S_MEMORY) && is_lw;
            c_o_MemWrite <= (state_d == S_MEMORY) && is_sw;
            c_o_RegWrite <= (state_d == S_WRITEBACK);
            c_o_RegDst   <= (state_d == S_WRITEBACK) && is_r;
            c_o_MemtoReg <= (state_d == S_WRITEBACK) && is_lw;

            c_o_illegal <= illegal_d;
            if (timeout) c_o_mem_err <= 1'b1;
            if (retire)  c_o_retired <= c_o_retired + RET_WIDTH'(1);
        end
    end

    assign c_o_state     = state_q;
    assign c_o_change_pc = c_o_Branch & c_i_zero;

endmodule
